// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: FSM state and op encodings.
package muldiv_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
endpackage

// File: rtl/muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider behind a start/busy/done handshake.
// Optional signed operation is enabled by defining MULDIV_SIGNED_EN.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULDIV_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] overflow,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, opnd;
  logic             op_q, neg_q, negr_q;
  logic             sgn_i, dz, last;
  logic [WIDTH-1:0] a_mag, b_mag;

`ifdef MULDIV_SIGNED_EN
  assign sgn_i = sgn;
`else
  assign sgn_i = 1'b0;
`endif

  assign dz    = (op == OP_DIV) && (b == '0);
  assign last  = (cnt == CW'(WIDTH - 1));
  assign a_mag = (sgn_i && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sgn_i && b[WIDTH-1]) ? -b : b;

  // One iteration step. hi holds the upper product half / partial remainder,
  // lo holds the multiplier being consumed / dividend shifting into quotient.
  logic [WIDTH:0]     msum;
  logic [WIDTH+1:0]   dtrial;
  logic [WIDTH-1:0]   hi_n, lo_n;

  always_comb begin
    msum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    dtrial = {1'b0, hi, lo[WIDTH-1]} - {2'b0, opnd};
    hi_n   = hi;
    lo_n   = lo;
    if (op_q == OP_MUL) begin
      hi_n = msum[WIDTH:1];
      lo_n = {msum[0], lo[WIDTH-1:1]};
    end else if (dtrial[WIDTH+1]) begin
      hi_n = {hi[WIDTH-2:0], lo[WIDTH-1]};
      lo_n = {lo[WIDTH-2:0], 1'b0};
    end else begin
      hi_n = dtrial[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], 1'b1};
    end
  end

  // Sign fix-up applied to the final iteration so it costs no extra cycle.
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, res_n, ovf_n;

  always_comb begin
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_n : lo_n;
    rem_s  = negr_q ? -hi_n : hi_n;
    if (op_q == OP_MUL) begin
      res_n = prod_s[WIDTH-1:0];
      ovf_n = prod_s[2*WIDTH-1:WIDTH];
    end else begin
      res_n = quo_s;
      ovf_n = rem_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = dz ? DONE : RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      opnd        <= '0;
      op_q        <= OP_MUL;
      neg_q       <= 1'b0;
      negr_q      <= 1'b0;
      result      <= '0;
      overflow    <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q        <= op;
          cnt         <= '0;
          hi          <= '0;
          lo          <= a_mag;
          opnd        <= b_mag;
          neg_q       <= sgn_i & (a[WIDTH-1] ^ b[WIDTH-1]);
          negr_q      <= sgn_i & a[WIDTH-1] & (op == OP_DIV);
          div_by_zero <= dz;
          if (dz) begin
            result   <= '1;
            overflow <= a;
          end
        end
        RUN: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt + CW'(1);
          if (last) begin
            result   <= res_n;
            overflow <= ovf_n;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (WIDTH=16); signed cases run when MULDIV_SIGNED_EN is defined.
module tb_muldiv_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0, b = '0;
`ifdef MULDIV_SIGNED_EN
  logic         sgn = 1'b0;
`endif
  logic         busy, done, div_by_zero;
  logic [W-1:0] result, overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
`ifdef MULDIV_SIGNED_EN
    .sgn(sgn),
`endif
    .busy(busy), .done(done), .result(result), .overflow(overflow),
    .div_by_zero(div_by_zero)
  );

  // Issue one operation; returns the cycle done was seen (-1 on timeout),
  // the number of busy cycles before it and any busy&done overlap.
  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int cyc, output int nbusy, output int both);
    @(negedge clk);
    while (busy || done) @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = ~x; b = ~y;
    cyc = 1; nbusy = 0; both = 0;
    while (!done && cyc < 64) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      cyc++;
    end
    if (busy && done) both++;
    if (!done) cyc = -1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b want 000", {busy, done, div_by_zero});
    end
    checks++;
    if ({overflow, result} !== 32'h0) begin
      errors++; $display("FAIL reset_out got %h want 00000000", {overflow, result});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    int cyc, nb, both;
    run_op(1'b0, 16'd300, 16'd300, cyc, nb, both);
    checks++;
    if (cyc !== 17) begin errors++; $display("FAIL mul_latency got %0d want 17", cyc); end
    checks++;
    if (nb !== 16) begin errors++; $display("FAIL mul_busy_cycles got %0d want 16", nb); end
    checks++;
    if (both !== 0) begin errors++; $display("FAIL mul_busy_done_overlap got %0d want 0", both); end
    checks++;
    if ({overflow, result} !== 32'h0001_5F90) begin
      errors++; $display("FAIL mul_300x300 got %h want 00015f90", {overflow, result});
    end
    run_op(1'b0, 16'hFFFF, 16'hFFFF, cyc, nb, both);
    checks++;
    if ({overflow, result} !== 32'hFFFE_0001) begin
      errors++; $display("FAIL mul_max got %h want fffe0001", {overflow, result});
    end
    run_op(1'b0, 16'h0000, 16'h1234, cyc, nb, both);
    checks++;
    if ({overflow, result} !== 32'h0) begin
      errors++; $display("FAIL mul_zero got %h want 00000000", {overflow, result});
    end
    run_op(1'b0, 16'h8000, 16'h0002, cyc, nb, both);
    checks++;
    if ({overflow, result} !== 32'h0001_0000) begin
      errors++; $display("FAIL mul_carry got %h want 00010000", {overflow, result});
    end
  endtask

  task automatic test_div();
    int cyc, nb, both;
    run_op(1'b1, 16'd1000, 16'd7, cyc, nb, both);
    checks++;
    if (cyc !== 17) begin errors++; $display("FAIL div_latency got %0d want 17", cyc); end
    checks++;
    if ({overflow, result, div_by_zero} !== {16'd6, 16'd142, 1'b0}) begin
      errors++; $display("FAIL div_1000_7 got r=%0d q=%0d z=%b want r=6 q=142 z=0",
                         overflow, result, div_by_zero);
    end
    run_op(1'b1, 16'd5, 16'd9, cyc, nb, both);
    checks++;
    if ({overflow, result} !== {16'd5, 16'd0}) begin
      errors++; $display("FAIL div_small got r=%0d q=%0d want r=5 q=0", overflow, result);
    end
    run_op(1'b1, 16'hFFFF, 16'h0001, cyc, nb, both);
    checks++;
    if ({overflow, result} !== {16'h0000, 16'hFFFF}) begin
      errors++; $display("FAIL div_by_one got r=%h q=%h want r=0000 q=ffff", overflow, result);
    end
    run_op(1'b1, 16'hFFFF, 16'hFFFF, cyc, nb, both);
    checks++;
    if ({overflow, result} !== {16'h0000, 16'h0001}) begin
      errors++; $display("FAIL div_self got r=%h q=%h want r=0000 q=0001", overflow, result);
    end
  endtask

  task automatic test_div_zero();
    int cyc, nb, both;
    run_op(1'b1, 16'h1234, 16'h0000, cyc, nb, both);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL dz_latency got %0d want 1", cyc); end
    checks++;
    if (nb !== 0) begin errors++; $display("FAIL dz_busy got %0d want 0", nb); end
    checks++;
    if ({overflow, result, div_by_zero} !== {16'h1234, 16'hFFFF, 1'b1}) begin
      errors++; $display("FAIL dz_out got r=%h q=%h z=%b want r=1234 q=ffff z=1",
                         overflow, result, div_by_zero);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({overflow, result, div_by_zero, done} !== {16'h1234, 16'hFFFF, 1'b1, 1'b0}) begin
      errors++; $display("FAIL dz_hold got r=%h q=%h z=%b d=%b want r=1234 q=ffff z=1 d=0",
                         overflow, result, div_by_zero, done);
    end
    run_op(1'b1, 16'd1000, 16'd7, cyc, nb, both);
    checks++;
    if ({div_by_zero, result} !== {1'b0, 16'd142}) begin
      errors++; $display("FAIL dz_clear got z=%b q=%0d want z=0 q=142", div_by_zero, result);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, ovl;
    d1 = -1; d2 = -1; ovl = 0;
    @(negedge clk);
    while (busy || done) @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'd300; b = 16'd300;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (busy && done) ovl++;
      if (done && d1 < 0) d1 = k;
      else if (done && d2 < 0) d2 = k;
    end
    start = 1'b0;
    checks++;
    if (d1 !== 17 || d2 !== 35) begin
      errors++; $display("FAIL b2b_spacing got %0d,%0d want 17,35", d1, d2);
    end
    checks++;
    if (ovl !== 0) begin errors++; $display("FAIL b2b_overlap got %0d want 0", ovl); end
  endtask

  task automatic test_reset_mid();
    int cyc, nb, both, saw;
    saw = 0;
    @(negedge clk);
    while (busy || done) @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'd300; b = 16'd300;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      start = (k == 5); op = 1'b1; b = 16'h0000;
      if (done) saw++;
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || saw !== 0) begin
      errors++; $display("FAIL ignore_start got busy=%b dones=%0d want busy=1 dones=0", busy, saw);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_by_zero, overflow, result} !== 35'h0) begin
      errors++; $display("FAIL midrun_reset got b=%b d=%b z=%b r=%h q=%h want all 0",
                         busy, done, div_by_zero, overflow, result);
    end
    saw = 0;
    repeat (2) begin @(negedge clk); if (done) saw++; end
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); if (done) saw++; end
    checks++;
    if (saw !== 0) begin errors++; $display("FAIL reset_no_done got %0d want 0", saw); end
    run_op(1'b1, 16'd1000, 16'd7, cyc, nb, both);
    checks++;
    if (cyc !== 17 || {overflow, result} !== {16'd6, 16'd142}) begin
      errors++; $display("FAIL post_reset_op got cyc=%0d r=%0d q=%0d want cyc=17 r=6 q=142",
                         cyc, overflow, result);
    end
  endtask

`ifdef MULDIV_SIGNED_EN
  task automatic test_signed();
    int cyc, nb, both;
    sgn = 1'b1;
    run_op(1'b1, 16'hFFF9, 16'h0002, cyc, nb, both);
    checks++;
    if ({overflow, result} !== {16'hFFFF, 16'hFFFD}) begin
      errors++; $display("FAIL sdiv_m7_2 got r=%h q=%h want r=ffff q=fffd", overflow, result);
    end
    run_op(1'b0, 16'hFFFD, 16'h0003, cyc, nb, both);
    checks++;
    if ({overflow, result} !== 32'hFFFF_FFF7 || cyc !== 17) begin
      errors++; $display("FAIL smul_m3_3 got %h cyc=%0d want fffffff7 cyc=17", {overflow, result}, cyc);
    end
    run_op(1'b1, 16'h8000, 16'hFFFF, cyc, nb, both);
    checks++;
    if ({overflow, result} !== {16'h0000, 16'h8000}) begin
      errors++; $display("FAIL sdiv_min_m1 got r=%h q=%h want r=0000 q=8000", overflow, result);
    end
    run_op(1'b1, 16'd7, 16'hFFFE, cyc, nb, both);
    checks++;
    if ({overflow, result} !== {16'h0001, 16'hFFFD}) begin
      errors++; $display("FAIL sdiv_7_m2 got r=%h q=%h want r=0001 q=fffd", overflow, result);
    end
    sgn = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
`ifdef MULDIV_SIGNED_EN
    test_signed();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
